// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-master SPRAM arbiter.
// Imported by rr_arb2 and spram_arbiter.
package spram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  typedef enum logic {
    GntI = 1'b0,
    GntD = 1'b1
  } grant_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] IbusSel = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers which master won last and favours the other.
// req[0] is the instruction bus, req[1] the data bus.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic       ck,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output grant_e     gnt
);

  grant_e last_q;

  // Reset as if the data bus won last so the instruction bus goes first.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GntD;
    end else if (advance) begin
      last_q <= gnt;
    end
  end

  always_comb begin
    gnt = GntI;
    case (req)
      2'b01:   gnt = GntI;
      2'b10:   gnt = GntD;
      default: gnt = (last_q == GntI) ? GntD : GntI;
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter between the SERV instruction and data buses in front of the SPRAM.
// One access per three cycles: IDLE samples, ISSUE strobes the SPRAM, RESP acks.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int unsigned WORDS = 32768,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        i_cyc,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_cyc,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  state_e state_q, state_d;
  grant_e gnt, gnt_q;

  logic          advance;
  logic          in_range;
  logic          granted_cyc;
  logic          req_we;
  logic [3:0]    req_sel;
  logic [29:0]   req_word;
  logic [31:0]   req_wdata;

  logic          ram_cyc_q;
  logic          ram_we_q;
  logic [3:0]    ram_sel_q;
  logic [AW-1:0] ram_addr_q;
  logic [31:0]   ram_wdata_q;
  logic          oor_q;
  logic          abort_q;

  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .ck      (ck),
    .rst_n   (rst_n),
    .req     ({d_cyc, i_cyc}),
    .advance (advance),
    .gnt     (gnt)
  );

  // Request mux for the master the arbiter currently favours.
  always_comb begin
    req_we    = 1'b0;
    req_sel   = IbusSel;
    req_word  = i_addr[31:2];
    req_wdata = '0;
    if (gnt == GntD) begin
      req_we    = d_we;
      req_sel   = d_sel;
      req_word  = d_addr[31:2];
      req_wdata = d_wdata;
    end
  end

  assign in_range = {2'b00, req_word} < WORDS;

  // State register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_cyc || d_cyc) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: grant pulse, abort sampling and response muxing.
  always_comb begin
    advance     = (state_q == StIdle) && (i_cyc || d_cyc);
    granted_cyc = (gnt_q == GntD) ? d_cyc : i_cyc;
    i_ack       = 1'b0;
    d_ack       = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    if ((state_q == StResp) && !abort_q) begin
      if (gnt_q == GntD) begin
        d_ack   = 1'b1;
        d_rdata = oor_q ? '0 : ram_rdata;
      end else begin
        i_ack   = 1'b1;
        i_rdata = oor_q ? '0 : ram_rdata;
      end
    end
  end

  // Request registers; everything except ram_cyc holds between accesses.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ram_cyc_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      gnt_q       <= GntD;
      oor_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      ram_cyc_q <= 1'b0;
      if (advance) begin
        ram_cyc_q   <= in_range;
        ram_we_q    <= req_we;
        ram_sel_q   <= req_sel;
        ram_addr_q  <= req_word[AW-1:0];
        ram_wdata_q <= req_wdata;
        gnt_q       <= gnt;
        oor_q       <= !in_range;
        abort_q     <= 1'b0;
      end
      // A master that lets go mid-access still gets its write, but no ack.
      if (state_q == StIssue) begin
        abort_q <= !granted_cyc;
      end
    end
  end

  assign ram_cyc   = ram_cyc_q;
  assign ram_we    = ram_we_q;
  assign ram_sel   = ram_sel_q;
  assign ram_addr  = {{(32 - AW){1'b0}}, ram_addr_q};
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: vector table, hand-written corner sequences,
// and randomized single/contended traffic against a word-array reference model.
module tb_spram_arbiter;

  localparam int unsigned Words = 32768;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cyc = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_cyc = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        ram_cyc;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int passed = 0;
  int total  = 0;
  logic last_d = 1'b1;  // which master the spec says was granted last

  logic [31:0] mem     [Words];  // SPRAM behavioural model
  logic [31:0] ref_mem [Words];  // expectation model for the random phase

  spram_arbiter #(.WORDS(Words), .AW(15)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .i_cyc     (i_cyc),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_cyc     (d_cyc),
    .d_we      (d_we),
    .d_sel     (d_sel),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .ram_cyc   (ram_cyc),
    .ram_we    (ram_we),
    .ram_sel   (ram_sel),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 ck = ~ck;

  // SPRAM: byte-lane writes, read data one cycle after the strobe.
  always @(posedge ck) begin
    if (ram_cyc === 1'b1) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_addr[14:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr[14:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] byte_addr);
    if ((byte_addr >> 2) >= Words) return 32'h0;
    return ref_mem[byte_addr[16:2]];
  endfunction

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_cyc;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_d) begin
      d_cyc = 1'b1; d_we = v.we; d_sel = v.sel; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_cyc = 1'b1; i_addr = v.addr;
    end
    tick();
    check($sformatf("vec%0d ram_cyc", idx), ram_cyc, v.exp_cyc);
    check($sformatf("vec%0d early ack", idx), {i_ack, d_ack}, 2'b00);
    if (v.exp_cyc) begin
      check($sformatf("vec%0d ram_addr", idx), ram_addr, v.exp_addr);
      check($sformatf("vec%0d ram_we", idx), ram_we, v.is_d & v.we);
      check($sformatf("vec%0d ram_sel", idx), ram_sel, v.is_d ? v.sel : 4'hF);
      if (v.we) check($sformatf("vec%0d ram_wdata", idx), ram_wdata, v.wdata);
    end
    tick();
    check($sformatf("vec%0d ack", idx), {i_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
    check($sformatf("vec%0d ram_cyc resp", idx), ram_cyc, 1'b0);
    if (!v.we) check($sformatf("vec%0d rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    check($sformatf("vec%0d idle rdata", idx), v.is_d ? i_rdata : d_rdata, 32'h0);
    i_cyc = 1'b0; d_cyc = 1'b0;
    last_d = v.is_d;
    tick();
  endtask

  // Check a completing access at its ack cycle and fold it into the model.
  task automatic complete(input logic is_d, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input int n);
    check($sformatf("rnd%0d ack", n), {i_ack, d_ack}, is_d ? 2'b01 : 2'b10);
    if (!(is_d && we))
      check($sformatf("rnd%0d rdata", n), is_d ? d_rdata : i_rdata, model_read(addr));
    if (is_d && we && ((addr >> 2) < Words))
      ref_mem[addr[16:2]] = merge(ref_mem[addr[16:2]], wdata, sel);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] w;
    if ($urandom_range(0, 7) == 0) w = Words + $urandom_range(0, 4000);
    else w = 256 + $urandom_range(0, 255);
    return (w << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int k = 0; k < Words; k++) begin
      mem[k]     = 32'(k) * 32'h9E37_79B1;
      ref_mem[k] = 32'(k) * 32'h9E37_79B1;
    end
    mem[4] = 32'hDEAD_BEEF;
    mem[2] = 32'hAABB_CCDD;

    //                 is_d we  sel    addr          wdata         cyc addr     rdata
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b1, 32'h4,    32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 1'b1, 4'h3, 32'h0000_0008, 32'h1234_5678, 1'b1, 32'h2,   32'h0};
    vecs[2]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0,        1'b1, 32'h2,    32'hAABB_5678};
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 32'h0002_0000, 32'h0,        1'b0, 32'h0,    32'h0};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 32'h40,  32'h0};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        1'b1, 32'h40,   32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 1'b1, 4'h8, 32'h0000_0100, 32'h1122_3344, 1'b1, 32'h40,  32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0101, 32'h0,        1'b1, 32'h40,   32'h11FE_F00D};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,        1'b0, 32'h0,    32'h0};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h0001_FFFC, 32'h5A5A_5A5A, 1'b1, 32'h7FFF, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 4'hF, 32'h0001_FFFC, 32'h0,        1'b1, 32'h7FFF, 32'h5A5A_5A5A};

    // Reset state.
    repeat (3) @(posedge ck);
    #1;
    check("reset acks", {i_ack, d_ack}, 2'b00);
    check("reset ram_cyc", ram_cyc, 1'b0);
    check("reset ram_we", ram_we, 1'b0);
    check("reset ram_sel", ram_sel, 4'h0);
    check("reset ram_addr", ram_addr, 32'h0);
    check("reset ram_wdata", ram_wdata, 32'h0);
    check("reset rdata", i_rdata | d_rdata, 32'h0);
    @(negedge ck);
    rst_n = 1'b1;
    tick();

    // Both masters held continuously from reset: i, d, i, d every three cycles.
    i_cyc = 1'b1; i_addr = 32'h10;
    d_cyc = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h8;
    for (int c = 1; c <= 11; c++) begin
      tick();
      check($sformatf("alt c%0d i_ack", c), i_ack, (c % 3 == 2) && ((c / 3) % 2 == 0));
      check($sformatf("alt c%0d d_ack", c), d_ack, (c % 3 == 2) && ((c / 3) % 2 == 1));
    end
    i_cyc = 1'b0; d_cyc = 1'b0;
    last_d = 1'b1;
    tick();

    for (int n = 0; n < 11; n++) run_vec(vecs[n], n);

    // Data write abandoned during ISSUE: write lands, no ack.
    d_cyc = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h960; d_wdata = 32'h0BAD_F00D;
    tick();
    check("abort ram_cyc", ram_cyc, 1'b1);
    d_cyc = 1'b0; d_we = 1'b0;
    tick();
    check("abort acks", {i_ack, d_ack}, 2'b00);
    tick();
    i_cyc = 1'b1; i_addr = 32'h960;
    tick();
    check("abort follow ram_cyc", ram_cyc, 1'b1);
    check("abort follow ram_addr", ram_addr, 32'd600);
    tick();
    check("abort follow i_ack", i_ack, 1'b1);
    check("abort write landed", i_rdata, 32'h0BAD_F00D);
    i_cyc = 1'b0;
    last_d = 1'b0;
    tick();

    // Random traffic, single and contended, in words 256..511 plus out of range.
    for (int n = 0; n < 40; n++) begin
      logic ir, dr, dwe, first_d;
      logic [3:0] dsel;
      logic [31:0] ia, da, dwd;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      ia = rnd_addr(); da = rnd_addr();
      dwe = 1'($urandom_range(0, 1)); dsel = 4'($urandom_range(1, 15)); dwd = $urandom;
      first_d = (ir && dr) ? !last_d : dr;
      i_cyc = ir; i_addr = ia;
      d_cyc = dr; d_we = dwe; d_sel = dsel; d_addr = da; d_wdata = dwd;
      tick();
      check($sformatf("rnd%0d issue acks", n), {i_ack, d_ack}, 2'b00);
      tick();
      complete(first_d, dwe, dsel, first_d ? da : ia, dwd, n);
      if (first_d) d_cyc = 1'b0; else i_cyc = 1'b0;
      last_d = first_d;
      if (ir && dr) begin
        tick();
        tick();
        check($sformatf("rnd%0d second issue acks", n), {i_ack, d_ack}, 2'b00);
        tick();
        complete(!first_d, dwe, dsel, first_d ? ia : da, dwd, n);
        i_cyc = 1'b0; d_cyc = 1'b0;
        last_d = !first_d;
      end
      tick();
    end

    // Reset while an ibus read is in RESP.
    i_cyc = 1'b1; i_addr = 32'h10;
    tick();
    tick();
    check("rst-resp i_ack before", i_ack, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst-resp i_ack", i_ack, 1'b0);
    check("rst-resp ram_cyc", ram_cyc, 1'b0);
    check("rst-resp ram_we", ram_we, 1'b0);
    check("rst-resp ram_sel", ram_sel, 4'h0);
    check("rst-resp ram_addr", ram_addr, 32'h0);
    check("rst-resp ram_wdata", ram_wdata, 32'h0);
    i_cyc = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    tick();
    i_cyc = 1'b1; i_addr = 32'h10;
    d_cyc = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h8;
    tick();
    tick();
    check("post-reset first grant", {i_ack, d_ack}, 2'b10);
    check("post-reset i_rdata", i_rdata, 32'hDEAD_BEEF);
    i_cyc = 1'b0;
    tick();
    tick();
    tick();
    check("post-reset second grant", {i_ack, d_ack}, 2'b01);
    check("post-reset d_rdata", d_rdata, 32'hAABB_5678);
    d_cyc = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
